// File: rtl/mem_wb_stage_if.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_if
// Purpose : bundles the instruction/memory request side and the register-file
//           writeback side of the memory-to-writeback pipeline stage.
// Signals :
//   in_valid/in_wb_en/in_is_load/in_ld_type/in_rd : instruction at the memory
//                                                   request cycle
//   flush                                         : kill input and M2 instr
//   mem_rd_data_l/h                               : registered memory bytes
//   wb_en/wb_rd/wb_data                           : register-file write port
// Modports:
//   master : pipeline/memory driver side (drives request, observes writeback)
//   slave  : the stage itself (consumes request, drives writeback)
// -----------------------------------------------------------------------------
interface mem_wb_stage_if #(
  parameter int REG_AW = 3,
  parameter int DW     = 16
) ();

  logic              in_valid;
  logic              in_wb_en;
  logic              in_is_load;
  logic [1:0]        in_ld_type;
  logic [REG_AW-1:0] in_rd;
  logic              flush;
  logic [7:0]        mem_rd_data_l;
  logic [7:0]        mem_rd_data_h;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [DW-1:0]     wb_data;

  modport master (
    output in_valid, in_wb_en, in_is_load, in_ld_type, in_rd, flush,
           mem_rd_data_l, mem_rd_data_h,
    input  wb_en, wb_rd, wb_data
  );

  modport slave (
    input  in_valid, in_wb_en, in_is_load, in_ld_type, in_rd, flush,
           mem_rd_data_l, mem_rd_data_h,
    output wb_en, wb_rd, wb_data
  );

endinterface

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Purpose : stage directly after the data memory. Delays the instruction's
//           control fields by one cycle (M2) to line up with the registered
//           memory output, extracts load data (word / signed byte / unsigned
//           byte / high byte), registers the register-file write, and provides
//           M2 forwarding, load-use stall detection and retire counters.
// Ports   :
//   clk, reset      : clock, asynchronous active-low reset
//   bus (slave)     : request fields, flush, memory bytes, writeback port
//   id_rs1/id_rs2   : decode-stage source registers
//   id_rs_use       : bit0 rs1 used, bit1 rs2 used
//   fwd_m2_valid/rd/data : forwardable non-load result sitting in M2
//   load_use_stall  : decode must stall one cycle
//   retire_cnt      : instructions written back
//   load_cnt        : loads written back
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int REG_AW = 3,
  parameter int DW     = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  mem_wb_stage_if.slave     bus,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [1:0]        id_rs_use,
  output logic              fwd_m2_valid,
  output logic [REG_AW-1:0] fwd_m2_rd,
  output logic [DW-1:0]     fwd_m2_data,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  load_cnt
);

  localparam logic [1:0] LD_WORD  = 2'b00;
  localparam logic [1:0] LD_SBYTE = 2'b01;
  localparam logic [1:0] LD_UBYTE = 2'b10;
  localparam logic [1:0] LD_HBYTE = 2'b11;

  logic              m2_valid_q, m2_valid_d;
  logic              m2_wb_en_q;
  logic              m2_is_load_q;
  logic [1:0]        m2_ld_type_q;
  logic [REG_AW-1:0] m2_rd_q;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [DW-1:0]     aligned;
  logic              in_hazard, m2_hazard;

  // True when rd is a source register that decode actually uses.
  function automatic logic usesReg(input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic [REG_AW-1:0] rs2,
                                   input logic [1:0]        use_mask);
    return (use_mask[0] && (rs1 == rd)) || (use_mask[1] && (rs2 == rd));
  endfunction

  // Load extraction; non-loads pass the full two-lane word untouched.
  always_comb begin
    aligned = {bus.mem_rd_data_h, bus.mem_rd_data_l};
    if (m2_is_load_q) begin
      case (m2_ld_type_q)
        LD_WORD:  aligned = {bus.mem_rd_data_h, bus.mem_rd_data_l};
        LD_SBYTE: aligned = {{8{bus.mem_rd_data_l[7]}}, bus.mem_rd_data_l};
        LD_UBYTE: aligned = {8'h00, bus.mem_rd_data_l};
        LD_HBYTE: aligned = {8'h00, bus.mem_rd_data_h};
        default:  aligned = {bus.mem_rd_data_h, bus.mem_rd_data_l};
      endcase
    end
  end

  // Next-state: flush kills both the incoming and the M2 instruction. The
  // counters advance at the same edge the write enters WB, so they already
  // include the instruction currently shown on the write port.
  always_comb begin
    m2_valid_d   = bus.in_valid & ~bus.flush;
    wb_en_d      = m2_valid_q & m2_wb_en_q & ~bus.flush;
    wb_rd_d      = wb_en_d ? m2_rd_q : wb_rd_q;
    wb_data_d    = wb_en_d ? aligned : wb_data_q;
    retire_cnt_d = retire_cnt_q + CNT_W'(wb_en_d);
    load_cnt_d   = load_cnt_q + CNT_W'(wb_en_d & m2_is_load_q);
  end

  // M2 and WB registers plus counters; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m2_valid_q   <= 1'b0;
      m2_wb_en_q   <= 1'b0;
      m2_is_load_q <= 1'b0;
      m2_ld_type_q <= 2'b00;
      m2_rd_q      <= '0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      retire_cnt_q <= '0;
      load_cnt_q   <= '0;
    end else begin
      m2_valid_q   <= m2_valid_d;
      m2_wb_en_q   <= bus.in_wb_en;
      m2_is_load_q <= bus.in_is_load;
      m2_ld_type_q <= bus.in_ld_type;
      m2_rd_q      <= bus.in_rd;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      retire_cnt_q <= retire_cnt_d;
      load_cnt_q   <= load_cnt_d;
    end
  end

  // Load-use: a pending load (at the input or in M2) whose result decode needs.
  // Gated by reset so the input-side path is quiet while held in reset.
  always_comb begin
    in_hazard      = bus.in_valid & bus.in_wb_en & bus.in_is_load &
                     usesReg(bus.in_rd, id_rs1, id_rs2, id_rs_use);
    m2_hazard      = m2_valid_q & m2_wb_en_q & m2_is_load_q &
                     usesReg(m2_rd_q, id_rs1, id_rs2, id_rs_use);
    load_use_stall = reset & ~bus.flush & (in_hazard | m2_hazard);
  end

  assign fwd_m2_valid = m2_valid_q & m2_wb_en_q & ~m2_is_load_q & ~bus.flush;
  assign fwd_m2_rd    = m2_rd_q;
  assign fwd_m2_data  = aligned;

  assign bus.wb_en   = wb_en_q;
  assign bus.wb_rd   = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign retire_cnt  = retire_cnt_q;
  assign load_cnt    = load_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Purpose : directed self-checking bench for mem_wb_stage. Each cycle inputs
//           are driven 1 time unit after the rising edge and outputs are
//           checked 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int REG_AW = 3;
  localparam int DW     = 16;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [1:0]        id_rs_use;
  logic              fwd_m2_valid;
  logic [REG_AW-1:0] fwd_m2_rd;
  logic [DW-1:0]     fwd_m2_data;
  logic              load_use_stall;
  logic [CNT_W-1:0]  retire_cnt;
  logic [CNT_W-1:0]  load_cnt;

  int passCount  = 0;
  int totalCount = 0;

  mem_wb_stage_if #(.REG_AW(REG_AW), .DW(DW)) bus ();

  mem_wb_stage #(.REG_AW(REG_AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs_use      (id_rs_use),
    .fwd_m2_valid   (fwd_m2_valid),
    .fwd_m2_rd      (fwd_m2_rd),
    .fwd_m2_data    (fwd_m2_data),
    .load_use_stall (load_use_stall),
    .retire_cnt     (retire_cnt),
    .load_cnt       (load_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls time.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  // Drive one cycle's worth of request fields, flush and memory bytes.
  task automatic applyStimulus(input logic v, input logic wbe, input logic ld,
                               input logic [1:0] lt, input logic [REG_AW-1:0] rd,
                               input logic fl, input logic [7:0] memH,
                               input logic [7:0] memL);
    bus.in_valid      = v;
    bus.in_wb_en      = wbe;
    bus.in_is_load    = ld;
    bus.in_ld_type    = lt;
    bus.in_rd         = rd;
    bus.flush         = fl;
    bus.mem_rd_data_h = memH;
    bus.mem_rd_data_l = memL;
    #1;
  endtask

  task automatic idle(input logic [7:0] memH, input logic [7:0] memL);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b0, memH, memL);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    // Reset with a matching load at the input: stall must still be low.
    reset     = 1'b0;
    id_rs1    = 3'd3;
    id_rs2    = 3'd0;
    id_rs_use = 2'b01;
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("rst_wb_en", 32'(bus.wb_en), 32'd0);
    checkOutput("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    checkOutput("rst_wb_data", 32'(bus.wb_data), 32'd0);
    checkOutput("rst_retire", 32'(retire_cnt), 32'd0);
    checkOutput("rst_load", 32'(load_cnt), 32'd0);
    checkOutput("rst_fwd", 32'(fwd_m2_valid), 32'd0);
    checkOutput("rst_stall", 32'(load_use_stall), 32'd0);
    id_rs_use = 2'b00;
    idle(8'h00, 8'h00);
    #5 reset = 1'b1;

    // Word load rd=3 at address holding {0x40,0x84}.
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 1'b0, 8'h00, 8'h00);
    cyc(); idle(8'h40, 8'h84);
    checkOutput("word_no_fwd", 32'(fwd_m2_valid), 32'd0);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("word_wb_en", 32'(bus.wb_en), 32'd1);
    checkOutput("word_wb_rd", 32'(bus.wb_rd), 32'd3);
    checkOutput("word_wb_data", 32'(bus.wb_data), 32'h4084);
    checkOutput("word_load_cnt", 32'(load_cnt), 32'd1);
    checkOutput("word_retire", 32'(retire_cnt), 32'd1);

    // Byte extraction types 01/10/11, back-to-back on rd=1,2,4.
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 3'd1, 1'b0, 8'h00, 8'h00);
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 8'h40, 8'h84);
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, 3'd4, 1'b0, 8'h40, 8'h84);
    checkOutput("sbyte_rd", 32'(bus.wb_rd), 32'd1);
    checkOutput("sbyte_data", 32'(bus.wb_data), 32'hFF84);
    cyc(); idle(8'h40, 8'h84);
    checkOutput("ubyte_rd", 32'(bus.wb_rd), 32'd2);
    checkOutput("ubyte_data", 32'(bus.wb_data), 32'h0084);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("hbyte_rd", 32'(bus.wb_rd), 32'd4);
    checkOutput("hbyte_data", 32'(bus.wb_data), 32'h0040);
    checkOutput("bytes_load_cnt", 32'(load_cnt), 32'd4);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("hold_wb_en", 32'(bus.wb_en), 32'd0);
    checkOutput("hold_wb_rd", 32'(bus.wb_rd), 32'd4);
    checkOutput("hold_wb_data", 32'(bus.wb_data), 32'h0040);

    // ALU pass-through rd=5; ld_type=01 must be ignored for a non-load.
    cyc(); applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 3'd5, 1'b0, 8'h00, 8'h00);
    cyc(); idle(8'h12, 8'h34);
    checkOutput("alu_fwd_valid", 32'(fwd_m2_valid), 32'd1);
    checkOutput("alu_fwd_rd", 32'(fwd_m2_rd), 32'd5);
    checkOutput("alu_fwd_data", 32'(fwd_m2_data), 32'h1234);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("alu_wb_data", 32'(bus.wb_data), 32'h1234);
    checkOutput("alu_retire", 32'(retire_cnt), 32'd5);
    checkOutput("alu_load_cnt", 32'(load_cnt), 32'd4);

    // Load-use via rs1: stall at input cycle and M2 cycle, clear afterwards.
    id_rs1 = 3'd2; id_rs2 = 3'd0; id_rs_use = 2'b01;
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd2, 1'b0, 8'h00, 8'h00);
    checkOutput("lu_stall_in", 32'(load_use_stall), 32'd1);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("lu_stall_m2", 32'(load_use_stall), 32'd1);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("lu_stall_clear", 32'(load_use_stall), 32'd0);

    // Same load but rs1 not used: no stall.
    id_rs_use = 2'b00;
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd2, 1'b0, 8'h00, 8'h00);
    checkOutput("lu_unused_in", 32'(load_use_stall), 32'd0);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("lu_unused_m2", 32'(load_use_stall), 32'd0);

    // Hazard via rs2.
    id_rs1 = 3'd0; id_rs2 = 3'd2; id_rs_use = 2'b10;
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd2, 1'b0, 8'h00, 8'h00);
    checkOutput("lu_rs2_in", 32'(load_use_stall), 32'd1);
    cyc(); idle(8'h00, 8'h00);

    // Flush suppresses the stall and kills that load.
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd2, 1'b1, 8'h00, 8'h00);
    checkOutput("lu_flush_in", 32'(load_use_stall), 32'd0);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("lu_flushed_m2", 32'(load_use_stall), 32'd0);
    id_rs_use = 2'b00;
    cyc(); idle(8'h00, 8'h00);
    checkOutput("lu_retire", 32'(retire_cnt), 32'd8);
    checkOutput("lu_load_cnt", 32'(load_cnt), 32'd7);

    // Flush: X in WB retires, A in M2 and B at input are killed.
    cyc(); applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 3'd6, 1'b0, 8'h00, 8'h00);
    cyc(); applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 3'd7, 1'b0, 8'h55, 8'h66);
    cyc(); applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 3'd1, 1'b1, 8'hAA, 8'hBB);
    checkOutput("fl_x_wb_en", 32'(bus.wb_en), 32'd1);
    checkOutput("fl_x_data", 32'(bus.wb_data), 32'h5566);
    checkOutput("fl_a_no_fwd", 32'(fwd_m2_valid), 32'd0);
    cyc(); idle(8'hCC, 8'hDD);
    checkOutput("fl_a_killed", 32'(bus.wb_en), 32'd0);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("fl_b_killed", 32'(bus.wb_en), 32'd0);
    checkOutput("fl_retire", 32'(retire_cnt), 32'd9);

    // Async reset while a load sits in M2 and an ALU result is in WB.
    cyc(); applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 3'd5, 1'b0, 8'h00, 8'h00);
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 1'b0, 8'h01, 8'h02);
    cyc(); idle(8'h40, 8'h84);
    checkOutput("ar_pre_wb_en", 32'(bus.wb_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("ar_wb_en", 32'(bus.wb_en), 32'd0);
    checkOutput("ar_wb_data", 32'(bus.wb_data), 32'd0);
    checkOutput("ar_retire", 32'(retire_cnt), 32'd0);
    checkOutput("ar_load_cnt", 32'(load_cnt), 32'd0);
    checkOutput("ar_fwd", 32'(fwd_m2_valid), 32'd0);
    #1 reset = 1'b1;
    cyc(); applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'd3, 1'b0, 8'h00, 8'h00);
    checkOutput("ar_flushed_wb", 32'(bus.wb_en), 32'd0);
    cyc(); idle(8'h40, 8'h84);
    checkOutput("ar_m2_no_wb", 32'(bus.wb_en), 32'd0);
    cyc(); idle(8'h00, 8'h00);
    checkOutput("ar_post_wb_en", 32'(bus.wb_en), 32'd1);
    checkOutput("ar_post_data", 32'(bus.wb_data), 32'h4084);
    checkOutput("ar_post_retire", 32'(retire_cnt), 32'd1);
    checkOutput("ar_post_load", 32'(load_cnt), 32'd1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
